// File: rtl/ad9361_burst_pack.sv
// ad9361_burst_pack: collects gated 4-channel AD9361 I/Q sample sets into a
// FIFO and emits them as framed bursts (header, one word per active channel,
// trailer with set count) on a registered ready/valid stream.
module ad9361_burst_pack #(
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 8,
    parameter int MAX_BURST  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_0_in,
    input  logic        valid_1_in,
    input  logic        valid_2_in,
    input  logic        valid_3_in,
    input  logic [11:0] data_i0_in,
    input  logic [11:0] data_q0_in,
    input  logic [11:0] data_i1_in,
    input  logic [11:0] data_q1_in,
    input  logic [11:0] data_i2_in,
    input  logic [11:0] data_q2_in,
    input  logic [11:0] data_i3_in,
    input  logic [11:0] data_q3_in,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        overflow
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDLE_W = $clog2(GAP_CYCLES + 1);
    // Entry layout: [101] end marker, [100] last set of burst, [99:96] mask,
    // [95:0] four {I,Q} pairs, channel n at [24n+23:24n].
    localparam int ENT_W  = 102;
    // Sample sets are admitted only below FIFO_DEPTH-2 entries, so the end
    // marker that closes an open burst always has room.
    localparam logic [CNT_W-1:0]  ACC_LIM = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [IDLE_W-1:0] GAP_LIM = IDLE_W'(GAP_CYCLES);
    localparam logic [15:0]       MAX_B   = 16'(MAX_BURST);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_TRL} state_t;

    // Input side
    logic [3:0]        in_mask;
    logic [95:0]       in_data;
    logic              set_acc;
    logic              wr_en;
    logic [ENT_W-1:0]  wr_ent;
    logic              open_q, open_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [15:0]       bcnt_q, bcnt_d;
    logic              overflow_q, overflow_d;

    // FIFO
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              rd_en;
    logic [ENT_W-1:0]  head;
    logic              empty, head_end, head_last;
    logic [3:0]        head_mask, avail, rest;
    logic [1:0]        sel_ch;
    logic [23:0]       sel_iq;

    // Output side
    state_t            state_q, state_d;
    logic [2:0]        chs_q, chs_d;
    logic              lastpop_q, lastpop_d;
    logic [15:0]       seq_q, seq_d, scnt_q, scnt_d;
    logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [31:0]       m_data_q, m_data_d;
    logic              out_free, emit;

    assign in_mask = {valid_3_in, valid_2_in, valid_1_in, valid_0_in};
    assign in_data = {data_i3_in, data_q3_in, data_i2_in, data_q2_in,
                      data_i1_in, data_q1_in, data_i0_in, data_q0_in};

    // Burst tracking: admit or drop sets, count idle gap, write end markers
    always_comb begin
        set_acc    = (|in_mask) && (count_q < ACC_LIM);
        wr_en      = 1'b0;
        wr_ent     = '0;
        open_d     = open_q;
        idle_d     = idle_q;
        bcnt_d     = bcnt_q;
        overflow_d = overflow_q;
        if (|in_mask) begin
            idle_d = '0;
            if (set_acc) begin
                wr_en = 1'b1;
                if (bcnt_q + 16'd1 == MAX_B) begin
                    wr_ent = {1'b0, 1'b1, in_mask, in_data};
                    open_d = 1'b0;
                    bcnt_d = '0;
                end else begin
                    wr_ent = {1'b0, 1'b0, in_mask, in_data};
                    open_d = 1'b1;
                    bcnt_d = bcnt_q + 16'd1;
                end
            end else begin
                overflow_d = 1'b1;
            end
        end else if (open_q) begin
            if (idle_q == GAP_LIM - 1'b1) begin
                wr_en  = 1'b1;
                wr_ent = {1'b1, 1'b0, 4'h0, 96'h0};
                open_d = 1'b0;
                idle_d = '0;
                bcnt_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // Burst tracking registers
    always_ff @(posedge clk) begin
        if (rst) begin
            open_q     <= 1'b0;
            idle_q     <= '0;
            bcnt_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            open_q     <= open_d;
            idle_q     <= idle_d;
            bcnt_q     <= bcnt_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage (payload only, no reset needed)
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_ent;
    end

    // FIFO pointers and occupancy; simultaneous write and read allowed
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    assign head      = mem[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign head_end  = head[101];
    assign head_last = head[100];
    assign head_mask = head[99:96];
    // Channels of the head entry not yet emitted
    assign avail     = head_mask & (4'hF << chs_q);
    assign rest      = avail & ~(4'b0001 << sel_ch);
    assign out_free  = !m_valid_q || m_ready;

    // Lowest pending channel of the head entry and its I/Q pair
    always_comb begin
        casez (avail)
            4'b???1: sel_ch = 2'd0;
            4'b??10: sel_ch = 2'd1;
            4'b?100: sel_ch = 2'd2;
            4'b1000: sel_ch = 2'd3;
            default: sel_ch = 2'd0;
        endcase
        case (sel_ch)
            2'd0:    sel_iq = head[23:0];
            2'd1:    sel_iq = head[47:24];
            2'd2:    sel_iq = head[71:48];
            default: sel_iq = head[95:72];
        endcase
    end

    // State register plus registered outputs and burst bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            chs_q     <= '0;
            lastpop_q <= 1'b0;
            seq_q     <= '0;
            scnt_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            chs_q     <= chs_d;
            lastpop_q <= lastpop_d;
            seq_q     <= seq_d;
            scnt_q    <= scnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    // Next state: the state names the word type held in the output register
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!empty && !head_end) state_d = S_HDR;
            S_HDR:  if (m_ready) state_d = S_DATA;
            S_DATA: if (out_free && (lastpop_q || (!empty && head_end))) state_d = S_TRL;
            S_TRL:  if (m_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output word selection, FIFO pop and counters
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        rd_en     = 1'b0;
        emit      = 1'b0;
        chs_d     = chs_q;
        lastpop_d = lastpop_q;
        seq_d     = seq_q;
        scnt_d    = scnt_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (head_end) begin
                        // Stray end marker with no open frame: discard it
                        rd_en = 1'b1;
                    end else begin
                        m_valid_d = 1'b1;
                        m_data_d  = {8'hA5, seq_q, 8'h00};
                        m_last_d  = 1'b0;
                    end
                end
            end
            S_HDR: begin
                if (m_ready) emit = 1'b1;
            end
            S_DATA: begin
                if (out_free) begin
                    if (lastpop_q) begin
                        m_valid_d = 1'b1;
                        m_data_d  = {8'h5A, 8'h00, scnt_q};
                        m_last_d  = 1'b1;
                        lastpop_d = 1'b0;
                    end else if (empty) begin
                        m_valid_d = 1'b0;
                    end else if (head_end) begin
                        rd_en     = 1'b1;
                        m_valid_d = 1'b1;
                        m_data_d  = {8'h5A, 8'h00, scnt_q};
                        m_last_d  = 1'b1;
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
            S_TRL: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_data_d  = '0;
                    m_last_d  = 1'b0;
                    seq_d     = seq_q + 16'd1;
                    scnt_d    = '0;
                end
            end
            default: ;
        endcase
        if (emit) begin
            m_valid_d = 1'b1;
            m_data_d  = {2'b01, sel_ch, 4'h0, sel_iq};
            m_last_d  = 1'b0;
            if (rest == 4'h0) begin
                // Last channel of this set loaded: retire the entry
                rd_en     = 1'b1;
                chs_d     = '0;
                scnt_d    = scnt_q + 16'd1;
                lastpop_d = head_last;
            end else begin
                chs_d = {1'b0, sel_ch} + 3'd1;
            end
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ad9361_burst_pack.sv
// Scoreboard bench for ad9361_burst_pack: two instances (default MAX_BURST
// and MAX_BURST=2) share stimulus lines, each gated by a select.
module tb_ad9361_burst_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel2;
    logic [3:0]  vmask;
    logic [11:0] di [4];
    logic [11:0] dq [4];
    logic        m_ready;
    logic [31:0] m_data1, m_data2;
    logic        m_valid1, m_valid2, m_last1, m_last2, overflow1, overflow2;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp1 [$];
    logic [32:0] exp2 [$];

    always #5 clk = ~clk;

    ad9361_burst_pack dut1 (
        .clk(clk), .rst(rst),
        .valid_0_in(vmask[0] & ~sel2), .valid_1_in(vmask[1] & ~sel2),
        .valid_2_in(vmask[2] & ~sel2), .valid_3_in(vmask[3] & ~sel2),
        .data_i0_in(di[0]), .data_q0_in(dq[0]), .data_i1_in(di[1]), .data_q1_in(dq[1]),
        .data_i2_in(di[2]), .data_q2_in(dq[2]), .data_i3_in(di[3]), .data_q3_in(dq[3]),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready), .m_last(m_last1),
        .overflow(overflow1)
    );

    ad9361_burst_pack #(.MAX_BURST(2)) dut2 (
        .clk(clk), .rst(rst),
        .valid_0_in(vmask[0] & sel2), .valid_1_in(vmask[1] & sel2),
        .valid_2_in(vmask[2] & sel2), .valid_3_in(vmask[3] & sel2),
        .data_i0_in(di[0]), .data_q0_in(dq[0]), .data_i1_in(di[1]), .data_q1_in(dq[1]),
        .data_i2_in(di[2]), .data_q2_in(dq[2]), .data_i3_in(di[3]), .data_q3_in(dq[3]),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready), .m_last(m_last2),
        .overflow(overflow2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [11:0] mk_i(input int k, input int c);
        return {4'(k + 1), 4'(c), 4'h1};
    endfunction

    function automatic logic [11:0] mk_q(input int k, input int c);
        return {4'(k + 1), 4'(c), 4'h2};
    endfunction

    // Pops expected words whenever a DUT word is accepted; checks hold on stall
    task automatic monitor();
        logic        stall1, stall2;
        logic [32:0] hold1, hold2, e;
        stall1 = 1'b0;
        stall2 = 1'b0;
        hold1 = '0;
        hold2 = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stall1) begin
                    chk("hold1_valid", 33'(m_valid1), 33'(1));
                    chk("hold1_word", {m_last1, m_data1}, hold1);
                end
                if (stall2) begin
                    chk("hold2_valid", 33'(m_valid2), 33'(1));
                    chk("hold2_word", {m_last2, m_data2}, hold2);
                end
                if (m_valid1 && m_ready) begin
                    if (exp1.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb1_unexpected: got %h, expected no word", {m_last1, m_data1});
                    end else begin
                        e = exp1.pop_front();
                        chk("sb1_word", {m_last1, m_data1}, e);
                    end
                end
                if (m_valid2 && m_ready) begin
                    if (exp2.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb2_unexpected: got %h, expected no word", {m_last2, m_data2});
                    end else begin
                        e = exp2.pop_front();
                        chk("sb2_word", {m_last2, m_data2}, e);
                    end
                end
            end
            stall1 = m_valid1 && !m_ready && !rst;
            stall2 = m_valid2 && !m_ready && !rst;
            hold1  = {m_last1, m_data1};
            hold2  = {m_last2, m_data2};
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp1.size() != 0 || exp2.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp1.size() != 0 || exp2.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d words pending, expected 0/0", exp1.size(), exp2.size());
        end
        repeat (3) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sel2 = 1'b0;
        vmask = 4'h0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            di[i] = '0;
            dq[i] = '0;
        end
        fork
            monitor();
        join_none
        repeat (4) tick();

        // Reset state
        chk("rst_valid", 33'(m_valid1), 33'(0));
        chk("rst_data", 33'(m_data1), 33'(0));
        chk("rst_last", 33'(m_last1), 33'(0));
        chk("rst_ovf", 33'(overflow1), 33'(0));
        rst = 1'b0;
        repeat (2) tick();

        // Single set, channels 0 and 2, closed by the idle gap
        di[0] = 12'h123; dq[0] = 12'hFFF; di[2] = 12'h800; dq[2] = 12'h001;
        exp1.push_back({1'b0, 32'hA5000000});
        exp1.push_back({1'b0, 32'h40123FFF});
        exp1.push_back({1'b0, 32'h60800001});
        exp1.push_back({1'b1, 32'h5A000001});
        vmask = 4'b0101;
        tick();
        vmask = 4'h0;
        chk("lat_t1_valid", 33'(m_valid1), 33'(0));
        tick();
        chk("lat_t2_valid", 33'(m_valid1), 33'(1));
        chk("lat_t2_hdr", 33'(m_data1), 33'h0A5000000);
        wait_drain(200);

        // Three full sets back to back, second burst so seq=1
        exp1.push_back({1'b0, 32'hA5000100});
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++)
                exp1.push_back({1'b0, 2'b01, 2'(c), 4'h0, mk_i(k, c), mk_q(k, c)});
        exp1.push_back({1'b1, 32'h5A000003});
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                di[c] = mk_i(k, c);
                dq[c] = mk_q(k, c);
            end
            vmask = 4'hF;
            tick();
        end
        vmask = 4'h0;
        wait_drain(300);

        // MAX_BURST=2 instance: 3 sets split into bursts of 2 and 1
        sel2 = 1'b1;
        exp2.push_back({1'b0, 32'hA5000000});
        exp2.push_back({1'b0, 32'h40A01B01});
        exp2.push_back({1'b0, 32'h50A02B02});
        exp2.push_back({1'b0, 32'h70A13B13});
        exp2.push_back({1'b1, 32'h5A000002});
        exp2.push_back({1'b0, 32'hA5000100});
        exp2.push_back({1'b0, 32'h60A22B22});
        exp2.push_back({1'b1, 32'h5A000001});
        di[0] = 12'hA01; dq[0] = 12'hB01; di[1] = 12'hA02; dq[1] = 12'hB02;
        vmask = 4'b0011;
        tick();
        di[3] = 12'hA13; dq[3] = 12'hB13;
        vmask = 4'b1000;
        tick();
        di[2] = 12'hA22; dq[2] = 12'hB22;
        vmask = 4'b0100;
        tick();
        vmask = 4'h0;
        wait_drain(300);
        sel2 = 1'b0;

        // Backpressure: 20 sets while stalled, only 14 fit
        m_ready = 1'b0;
        exp1.push_back({1'b0, 32'hA5000200});
        for (int i = 0; i < 14; i++)
            exp1.push_back({1'b0, 8'h40, 12'(i + 1), 12'(3840 + i)});
        exp1.push_back({1'b1, 32'h5A00000E});
        for (int i = 0; i < 20; i++) begin
            di[0] = 12'(i + 1);
            dq[0] = 12'(3840 + i);
            vmask = 4'h1;
            tick();
        end
        vmask = 4'h0;
        repeat (12) tick();
        chk("ovf_set", 33'(overflow1), 33'(1));
        chk("ovf_other", 33'(overflow2), 33'(0));
        chk("stall_hdr", {m_valid1, m_data1}, {1'b1, 32'hA5000200});
        m_ready = 1'b1;
        wait_drain(400);
        chk("ovf_sticky", 33'(overflow1), 33'(1));

        // Reset mid-burst with toggling ready
        exp1.push_back({1'b0, 32'hA5000300});
        for (int k = 3; k < 6; k++)
            for (int c = 0; c < 4; c++)
                exp1.push_back({1'b0, 2'b01, 2'(c), 4'h0, mk_i(k, c), mk_q(k, c)});
        for (int k = 3; k < 6; k++) begin
            for (int c = 0; c < 4; c++) begin
                di[c] = mk_i(k, c);
                dq[c] = mk_q(k, c);
            end
            vmask = 4'hF;
            m_ready = ~m_ready;
            tick();
        end
        vmask = 4'h0;
        repeat (5) begin
            m_ready = ~m_ready;
            tick();
        end
        chk("pre_rst_busy", 33'(exp1.size() > 0), 33'(1));
        rst = 1'b1;
        tick();
        chk("post_rst_valid", 33'(m_valid1), 33'(0));
        chk("post_rst_data", 33'(m_data1), 33'(0));
        chk("post_rst_last", 33'(m_last1), 33'(0));
        chk("post_rst_ovf", 33'(overflow1), 33'(0));
        exp1.delete();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        di[0] = 12'hABC; dq[0] = 12'hDEF;
        exp1.push_back({1'b0, 32'hA5000000});
        exp1.push_back({1'b0, 32'h40ABCDEF});
        exp1.push_back({1'b1, 32'h5A000001});
        vmask = 4'h1;
        tick();
        vmask = 4'h0;
        wait_drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
